fb_rect_writer: RTL and testbench

Framebuffer fill engine: the writer-side counterpart of the LCD scan-out path. It accepts rectangle-fill commands over a valid/ready handshake and writes 4-bit palette indices into the 640×480 framebuffer RAM, one pixel per clock. It sits between game/sprite logic and the RAM write port, in the same `pixel_clock` domain as the scan-out reader.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_rect_clip.sv | 22 ++
 rtl/fb_rect_writer.sv | 121 ++++++++++++
 tb/tb_fb_rect_writer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, writer state encoding and rectangle command shared by writer and scan-out.
package fb_pkg;
    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int PIX_W  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_WRITE,
        S_DONE
    } fb_wr_state_t;

    typedef struct packed {
        logic [9:0]       x;
        logic [9:0]       y;
        logic [9:0]       w;
        logic [9:0]       h;
        logic [PIX_W-1:0] color;
        logic             sync;
    } fb_rect_cmd_t;
endpackage

// File: rtl/fb_rect_clip.sv
// fb_rect_clip: clips a rectangle to the visible area and forms its top-left word address without a multiplier.
module fb_rect_clip
    import fb_pkg::*;
(
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic [9:0]        w,
    input  logic [9:0]        h,
    output logic [10:0]       w_eff,
    output logic [10:0]       h_eff,
    output logic [ADDR_W-1:0] base
);
    logic [10:0] x_rem, y_rem;
    always_comb begin
        x_rem = 11'(H_RES) - {1'b0, x};
        y_rem = 11'(V_RES) - {1'b0, y};
        w_eff = ({1'b0, x} >= 11'(H_RES)) ? 11'd0 : ({1'b0, w} < x_rem) ? {1'b0, w} : x_rem;
        h_eff = ({1'b0, y} >= 11'(V_RES)) ? 11'd0 : ({1'b0, h} < y_rem) ? {1'b0, h} : y_rem;
        // y*640 = y*512 + y*128; only meaningful when y is on screen
        base  = ADDR_W'({y, 9'd0}) + ADDR_W'({y, 7'd0}) + ADDR_W'(x);
    end
endmodule

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: accepts rectangle-fill commands and writes the fill index into the framebuffer, one pixel per clock.
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic              pixel_clock,
    input  logic              pixel_reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [9:0]        cmd_w,
    input  logic [9:0]        cmd_h,
    input  logic [PIX_W-1:0]  cmd_color,
    input  logic              cmd_sync,
    input  logic              vblank,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

    fb_wr_state_t      state;
    fb_rect_cmd_t      cmd;
    logic [10:0]       clip_w, clip_h, w_eff, h_eff, col, row;
    logic [ADDR_W-1:0] clip_base, row_base;
    logic              last_col, last_row;

    fb_rect_clip u_clip (
        .x     (cmd.x),
        .y     (cmd.y),
        .w     (cmd.w),
        .h     (cmd.h),
        .w_eff (clip_w),
        .h_eff (clip_h),
        .base  (clip_base)
    );

    assign last_col = col == w_eff - 11'd1;
    assign last_row = row == h_eff - 11'd1;

    always_ff @(posedge pixel_clock or negedge pixel_reset) begin
        if (!pixel_reset) begin
            state     <= S_IDLE;
            cmd       <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fb_we     <= 1'b0;
            fb_addr   <= '0;
            fb_data   <= '0;
            w_eff     <= '0;
            h_eff     <= '0;
            col       <= '0;
            row       <= '0;
            row_base  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd       <= '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color, sync: cmd_sync};
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    w_eff    <= clip_w;
                    h_eff    <= clip_h;
                    row_base <= clip_base;
                    col      <= '0;
                    row      <= '0;
                    if (clip_w == 11'd0 || clip_h == 11'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (cmd.sync && !vblank) begin
                        state <= S_WAIT;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_addr <= clip_base;
                        fb_data <= cmd.color;
                        state   <= S_WRITE;
                    end
                end
                S_WAIT: begin
                    if (vblank) begin
                        fb_we   <= 1'b1;
                        fb_addr <= row_base;
                        fb_data <= cmd.color;
                        state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (last_col && last_row) begin
                        fb_we <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (last_col) begin
                        col      <= '0;
                        row      <= row + 11'd1;
                        row_base <= row_base + ROW_STEP;
                        fb_addr  <= row_base + ROW_STEP;
                    end else begin
                        col     <= col + 11'd1;
                        fb_addr <= fb_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: randomized fill commands checked against a per-pixel address model and cycle-exact handshake timing.
module tb_fb_rect_writer;
    import fb_pkg::*;

    logic              pixel_clock = 1'b0;
    logic              pixel_reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [9:0]        cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
    logic [PIX_W-1:0]  cmd_color = '0;
    logic              cmd_sync = 1'b0;
    logic              vblank = 1'b0;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [PIX_W-1:0]  fb_data;
    logic              busy, done;

    int         checks = 0, passed = 0;
    int         exp_q[$];
    int         exp_a;
    logic [3:0] exp_color = '0;

    fb_rect_writer dut (
        .pixel_clock (pixel_clock),
        .pixel_reset (pixel_reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_w       (cmd_w),
        .cmd_h       (cmd_h),
        .cmd_color   (cmd_color),
        .cmd_sync    (cmd_sync),
        .vblank      (vblank),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .busy        (busy),
        .done        (done)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Expected write addresses in raster order for the clipped rectangle
    function automatic int build(input int x, input int y, input int w, input int h);
        int we, he;
        we = (x >= H_RES) ? 0 : ((w < H_RES - x) ? w : H_RES - x);
        he = (y >= V_RES) ? 0 : ((h < V_RES - y) ? h : V_RES - y);
        exp_q.delete();
        for (int r = 0; r < he; r++)
            for (int c = 0; c < we; c++)
                exp_q.push_back((y + r) * H_RES + x + c);
        return we * he;
    endfunction

    always @(negedge pixel_clock) begin
        if (pixel_reset && fb_we) begin
            if (exp_q.size() == 0) begin
                check("extra_write", fb_addr, -1);
            end else begin
                exp_a = exp_q.pop_front();
                check("wr_addr", fb_addr, exp_a);
                check("wr_data", fb_data, exp_color);
            end
        end
    end

    task automatic handshake(input int x, input int y, input int w, input int h,
                             input logic [3:0] color, input logic sync);
        int c;
        c = 0;
        while (!cmd_ready && c < 20) begin
            @(posedge pixel_clock); #1;
            c++;
        end
        check("ready_before", cmd_ready, 1);
        cmd_x = 10'(x); cmd_y = 10'(y); cmd_w = 10'(w); cmd_h = 10'(h);
        cmd_color = color; cmd_sync = sync; cmd_valid = 1'b1;
        @(posedge pixel_clock); #1;
        cmd_valid = 1'b0;
        cmd_x = 10'($urandom); cmd_y = 10'($urandom); cmd_w = 10'($urandom);
        cmd_h = 10'($urandom); cmd_color = 4'($urandom); cmd_sync = 1'($urandom);
        check("ready_after_accept", cmd_ready, 0);
        check("busy_after_accept", busy, 1);
    endtask

    // d = vblank-low edges seen before the first write when sync is set
    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input logic [3:0] color, input logic sync, input int d, input bit toggle);
        int n, expd, c;
        n = build(x, y, w, h);
        exp_color = color;
        expd = (n == 0) ? 1 : n + 1 + (sync ? d : 0);
        vblank = sync ? (d == 0) : 1'($urandom);
        handshake(x, y, w, h, color, sync);
        for (c = 1; c <= expd + 20; c++) begin
            @(posedge pixel_clock); #1;
            if (sync && n > 0 && c <= d) check("we_in_wait", fb_we, 0);
            if (sync && c == d) vblank = 1'b1;
            else if (toggle && (!sync || c > d)) vblank = 1'($urandom);
            if (done) break;
        end
        check("done_cycle", c, expd);
        check("pixels_left", exp_q.size(), 0);
        check("we_at_done", fb_we, 0);
        @(posedge pixel_clock); #1;
        check("done_pulse", done, 0);
        check("busy_cleared", busy, 0);
        check("ready_restored", cmd_ready, 1);
    endtask

    initial begin
        int n;
        int lit4[4] = '{641, 642, 1281, 1282};
        int lit2[2] = '{307198, 307199};

        repeat (3) @(posedge pixel_clock);
        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_data, 0);
        pixel_reset = 1'b1;
        @(posedge pixel_clock); #1;
        check("ready_after_release", cmd_ready, 1);

        n = build(1, 1, 2, 2);
        check("model_2x2_n", n, 4);
        for (int i = 0; i < 4; i++) check("model_2x2_addr", exp_q[i], lit4[i]);
        run_cmd(1, 1, 2, 2, 4'd5, 1'b0, 0, 1'b0);

        n = build(638, 479, 5, 3);
        check("model_clip_n", n, 2);
        for (int i = 0; i < 2; i++) check("model_clip_addr", exp_q[i], lit2[i]);
        run_cmd(638, 479, 5, 3, 4'd9, 1'b0, 0, 1'b0);

        n = build(700, 10, 5, 5);
        check("model_offscreen_n", n, 0);
        run_cmd(700, 10, 5, 5, 4'd2, 1'b0, 0, 1'b1);
        run_cmd(3, 4, 0, 10, 4'd7, 1'b0, 0, 1'b1);
        run_cmd(20, 500, 4, 4, 4'd1, 1'b1, 3, 1'b0);
        run_cmd(10, 10, 8, 4, 4'd3, 1'b1, 10, 1'b1);
        run_cmd(600, 0, 40, 3, 4'd15, 1'b1, 0, 1'b1);
        run_cmd(0, 0, 640, 40, 4'd0, 1'b0, 0, 1'b0);
        run_cmd(0, 440, 640, 40, 4'd11, 1'b0, 0, 1'b1);

        for (int t = 0; t < 25; t++)
            run_cmd($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 64),
                    $urandom_range(0, 24), 4'($urandom), 1'($urandom), $urandom_range(0, 6), 1'b1);

        // Abandon a fill part-way through with an asynchronous reset
        n = build(100, 100, 100, 100);
        exp_color = 4'd6;
        vblank = 1'b0;
        handshake(100, 100, 100, 100, 4'd6, 1'b0);
        repeat (50) @(posedge pixel_clock);
        #3;
        check("mid_we_before", fb_we, 1);
        pixel_reset = 1'b0;
        #1;
        check("abort_we", fb_we, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", cmd_ready, 0);
        exp_q.delete();
        @(posedge pixel_clock); #3;
        pixel_reset = 1'b1;
        @(posedge pixel_clock); #1;
        check("ready_after_abort", cmd_ready, 1);
        check("idle_we_after_abort", fb_we, 0);
        run_cmd(5, 7, 6, 3, 4'd12, 1'b0, 0, 1'b1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
